// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between the imem output register and decode; flush on redirect.
// Optional macro FQ_BYPASS_EN adds a zero-latency path from fetch to decode when the queue is empty.
module fetch_queue #(
  parameter int PC_W  = 32,
  parameter int IW    = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             fq_clk,
  input  logic             fq_rst,
  input  logic             fq_i_ce,
  input  logic [PC_W-1:0]  fq_i_pc,
  input  logic [IW-1:0]    fq_i_instr,
  output logic             fq_o_ready,
  input  logic             fq_i_stall,
  input  logic             fq_i_flush,
  output logic             fq_o_ce,
  output logic [PC_W-1:0]  fq_o_pc,
  output logic [IW-1:0]    fq_o_instr,
  output logic [CNT_W-1:0] fq_o_count,
  output logic             fq_o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PC_W-1:0]  mem_pc    [DEPTH];
  logic [IW-1:0]    mem_instr [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             overflow;
  logic             full;
  logic             empty;
  logic             push;
  logic             bypass;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == FULL_CNT);
  assign empty = (count == {CNT_W{1'b0}});
  assign push  = fq_i_ce & ~full;

`ifdef FQ_BYPASS_EN
  assign bypass = empty & ~fq_i_flush & fq_i_ce;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word taken by an unstalled decode never touches storage.
  assign wr_en = push & ~fq_i_flush & ~(bypass & ~fq_i_stall);
  assign rd_en = ~empty & ~fq_i_stall & ~fq_i_flush;

  // Occupancy next-state: flush wins, otherwise net of write and read.
  always_comb begin
    count_nxt = count;
    if (fq_i_flush) begin
      count_nxt = {CNT_W{1'b0}};
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count_nxt = count + CNT_W'(1);
        2'b01:   count_nxt = count - CNT_W'(1);
        default: count_nxt = count;
      endcase
    end
  end

  // Control state: pointers, occupancy and sticky overflow.
  always_ff @(posedge fq_clk or posedge fq_rst) begin
    if (fq_rst) begin
      wr_ptr   <= {PTR_W{1'b0}};
      rd_ptr   <= {PTR_W{1'b0}};
      count    <= {CNT_W{1'b0}};
      overflow <= 1'b0;
    end else begin
      count    <= count_nxt;
      overflow <= overflow | (fq_i_ce & full & ~fq_i_flush);
      if (fq_i_flush) begin
        wr_ptr <= {PTR_W{1'b0}};
        rd_ptr <= {PTR_W{1'b0}};
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
        if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge fq_clk) begin
    if (wr_en) begin
      mem_pc[wr_ptr]    <= fq_i_pc;
      mem_instr[wr_ptr] <= fq_i_instr;
    end
  end

  // Head presentation toward decode.
  always_comb begin
    fq_o_ce    = ~empty | bypass;
    fq_o_pc    = {PC_W{1'b0}};
    fq_o_instr = {IW{1'b0}};
    if (!empty) begin
      fq_o_pc    = mem_pc[rd_ptr];
      fq_o_instr = mem_instr[rd_ptr];
    end else if (bypass) begin
      fq_o_pc    = fq_i_pc;
      fq_o_instr = fq_i_instr;
    end else begin
      fq_o_pc    = {PC_W{1'b0}};
      fq_o_instr = {IW{1'b0}};
    end
  end

  assign fq_o_ready    = ~full;
  assign fq_o_count    = count;
  assign fq_o_overflow = overflow;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic against a queue model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        fq_clk = 1'b0;
  logic        fq_rst;
  logic        fq_i_ce;
  logic [31:0] fq_i_pc;
  logic [31:0] fq_i_instr;
  logic        fq_o_ready;
  logic        fq_i_stall;
  logic        fq_i_flush;
  logic        fq_o_ce;
  logic [31:0] fq_o_pc;
  logic [31:0] fq_o_instr;
  logic [2:0]  fq_o_count;
  logic        fq_o_overflow;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] q_pc[$];
  logic [31:0] q_in[$];
  bit          m_ovf = 1'b0;

  fetch_queue #(.PC_W(32), .IW(32), .DEPTH(DEPTH), .CNT_W(3)) dut (
    .fq_clk(fq_clk), .fq_rst(fq_rst), .fq_i_ce(fq_i_ce), .fq_i_pc(fq_i_pc),
    .fq_i_instr(fq_i_instr), .fq_o_ready(fq_o_ready), .fq_i_stall(fq_i_stall),
    .fq_i_flush(fq_i_flush), .fq_o_ce(fq_o_ce), .fq_o_pc(fq_o_pc),
    .fq_o_instr(fq_o_instr), .fq_o_count(fq_o_count), .fq_o_overflow(fq_o_overflow)
  );

  always #5 fq_clk = ~fq_clk;

  function automatic bit byp();
`ifdef FQ_BYPASS_EN
    return (q_pc.size() == 0) && !fq_i_flush && fq_i_ce;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_ce();
    return (q_pc.size() != 0) || byp();
  endfunction

  function automatic logic [31:0] exp_pc();
    if (q_pc.size() != 0) return q_pc[0];
    else if (byp()) return fq_i_pc;
    else return 32'h0;
  endfunction

  function automatic logic [31:0] exp_instr();
    if (q_in.size() != 0) return q_in[0];
    else if (byp()) return fq_i_instr;
    else return 32'h0;
  endfunction

  task automatic drive(input bit ce, input logic [31:0] pc, input bit stall, input bit flush);
    @(negedge fq_clk);
    fq_i_ce    = ce;
    fq_i_pc    = pc;
    fq_i_instr = $urandom;
    fq_i_stall = stall;
    fq_i_flush = flush;
    #1;
  endtask

  // Advance the model across one rising edge using the applied inputs.
  task automatic edge_update();
    bit full;
    bit take;
    @(posedge fq_clk);
    if (fq_i_flush) begin
      q_pc.delete();
      q_in.delete();
    end else begin
      full = (q_pc.size() == DEPTH);
      take = byp() && !fq_i_stall;
      if (!take) begin
        if (fq_i_ce && full) m_ovf = 1'b1;
        if (q_pc.size() != 0 && !fq_i_stall) begin
          void'(q_pc.pop_front());
          void'(q_in.pop_front());
        end
        if (fq_i_ce && !full) begin
          q_pc.push_back(fq_i_pc);
          q_in.push_back(fq_i_instr);
        end
      end
    end
  endtask

  task automatic test_reset();
    fq_rst = 1'b1; fq_i_ce = 1'b0; fq_i_pc = 32'h0; fq_i_instr = 32'h0;
    fq_i_stall = 1'b0; fq_i_flush = 1'b0;
    #12;
    n_vec++;
    if (fq_o_ce !== 1'b0 || fq_o_pc !== 32'h0 || fq_o_instr !== 32'h0 ||
        fq_o_ready !== 1'b1 || fq_o_count !== 3'd0 || fq_o_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: ce=%b pc=%h instr=%h rdy=%b cnt=%0d ovf=%b, need 0/0/0/1/0/0",
               fq_o_ce, fq_o_pc, fq_o_instr, fq_o_ready, fq_o_count, fq_o_overflow);
    end
    @(negedge fq_clk);
    fq_rst = 1'b0;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      drive(i < 3, 32'(4 * i), 1'b0, 1'b0);
      n_vec++;
      if (fq_o_ce !== exp_ce() || fq_o_pc !== exp_pc() || fq_o_instr !== exp_instr()) begin
        n_err++;
        $display("FAIL stream_head[%0d]: ce=%b pc=%h, need ce=%b pc=%h", i, fq_o_ce, fq_o_pc, exp_ce(), exp_pc());
      end
      n_vec++;
      if (fq_o_count > 3'd1) begin
        n_err++;
        $display("FAIL stream_count[%0d]: count=%0d, need <=1", i, fq_o_count);
      end
      edge_update();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    n_vec++;
    if (fq_o_ce !== 1'b0) begin
      n_err++;
      $display("FAIL stream_drained: ce=%b, need 0", fq_o_ce);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h200 + 32'(4 * i), 1'b1, 1'b0);
      edge_update();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h208 + 32'(4 * i), 1'b0, 1'b0);
      n_vec++;
      if (fq_o_count !== 3'd2 || fq_o_pc !== exp_pc() || fq_o_instr !== exp_instr() ||
          fq_o_overflow !== 1'b0) begin
        n_err++;
        $display("FAIL wrap[%0d]: count=%0d pc=%h ovf=%b, need 2 pc=%h ovf=0",
                 i, fq_o_count, fq_o_pc, fq_o_overflow, exp_pc());
      end
      edge_update();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      n_vec++;
      if (fq_o_pc !== exp_pc() || fq_o_ce !== exp_ce()) begin
        n_err++;
        $display("FAIL wrap_drain[%0d]: pc=%h ce=%b, need pc=%h ce=%b", i, fq_o_pc, fq_o_ce, exp_pc(), exp_ce());
      end
      edge_update();
    end
  endtask

  task automatic test_overflow();
    logic [31:0] heads [4];
    heads[0] = 32'h10; heads[1] = 32'h14; heads[2] = 32'h18; heads[3] = 32'h1C;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h10 + 32'(4 * i), 1'b1, 1'b0);
      n_vec++;
      if (fq_o_count !== 3'(i < 4 ? i : 4) || fq_o_overflow !== 1'b0) begin
        n_err++;
        $display("FAIL fill[%0d]: count=%0d ovf=%b, need %0d ovf=0", i, fq_o_count, fq_o_overflow, (i < 4 ? i : 4));
      end
      edge_update();
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    n_vec++;
    if (fq_o_count !== 3'd4 || fq_o_ready !== 1'b0 || fq_o_overflow !== 1'b1) begin
      n_err++;
      $display("FAIL full_state: count=%0d rdy=%b ovf=%b, need 4/0/1", fq_o_count, fq_o_ready, fq_o_overflow);
    end
    edge_update();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      n_vec++;
      if (i < 4 ? (fq_o_ce !== 1'b1 || fq_o_pc !== heads[i]) : (fq_o_ce !== 1'b0)) begin
        n_err++;
        $display("FAIL drain[%0d]: ce=%b pc=%h, need ce=%b pc=%h", i, fq_o_ce, fq_o_pc, (i < 4), (i < 4 ? heads[i] : 32'h0));
      end
      edge_update();
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h30 + 32'(4 * i), 1'b1, 1'b0);
      edge_update();
    end
    drive(1'b1, 32'h3C, 1'b1, 1'b1);
    edge_update();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    n_vec++;
    if (fq_o_count !== 3'd0 || fq_o_ce !== 1'b0 || fq_o_ready !== 1'b1 || fq_o_overflow !== m_ovf) begin
      n_err++;
      $display("FAIL flush: count=%0d ce=%b rdy=%b ovf=%b, need 0/0/1/%b", fq_o_count, fq_o_ce, fq_o_ready, fq_o_overflow, m_ovf);
    end
    edge_update();
    drive(1'b1, 32'h40, 1'b0, 1'b0);
    n_vec++;
    if (fq_o_ce !== exp_ce() || fq_o_pc !== exp_pc()) begin
      n_err++;
      $display("FAIL post_flush_push: ce=%b pc=%h, need ce=%b pc=%h", fq_o_ce, fq_o_pc, exp_ce(), exp_pc());
    end
    edge_update();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    n_vec++;
    if (fq_o_ce !== exp_ce() || fq_o_pc !== exp_pc() || fq_o_instr !== exp_instr()) begin
      n_err++;
      $display("FAIL post_flush_head: ce=%b pc=%h, need ce=%b pc=%h", fq_o_ce, fq_o_pc, exp_ce(), exp_pc());
    end
    edge_update();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h50 + 32'(4 * i), 1'b1, 1'b0);
      edge_update();
    end
    #2;
    fq_i_ce = 1'b0;
    fq_rst  = 1'b1;
    #1;
    n_vec++;
    if (fq_o_ce !== 1'b0 || fq_o_count !== 3'd0 || fq_o_pc !== 32'h0 || fq_o_instr !== 32'h0 ||
        fq_o_overflow !== 1'b0 || fq_o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset: ce=%b cnt=%0d pc=%h instr=%h ovf=%b rdy=%b, need 0/0/0/0/0/1",
               fq_o_ce, fq_o_count, fq_o_pc, fq_o_instr, fq_o_overflow, fq_o_ready);
    end
    q_pc.delete(); q_in.delete(); m_ovf = 1'b0;
    @(negedge fq_clk);
    fq_rst = 1'b0;
    drive(1'b1, 32'h80, 1'b0, 1'b0);
    edge_update();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    n_vec++;
    if (fq_o_ce !== exp_ce() || fq_o_pc !== exp_pc()) begin
      n_err++;
      $display("FAIL post_reset_push: ce=%b pc=%h, need ce=%b pc=%h", fq_o_ce, fq_o_pc, exp_ce(), exp_pc());
    end
    edge_update();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h90 + 32'(4 * i), 1'b1, 1'b0);
      edge_update();
    end
    drive(1'b1, 32'hA0, 1'b1, 1'b1);
    edge_update();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    n_vec++;
    if (fq_o_overflow !== 1'b0 || fq_o_count !== 3'd0) begin
      n_err++;
      $display("FAIL flush_full_push: ovf=%b cnt=%0d, need ovf=0 cnt=0", fq_o_overflow, fq_o_count);
    end
    edge_update();
  endtask

`ifdef FQ_BYPASS_EN
  task automatic test_bypass();
    drive(1'b1, 32'h100, 1'b0, 1'b0);
    n_vec++;
    if (fq_o_ce !== 1'b1 || fq_o_pc !== 32'h100 || fq_o_count !== 3'd0) begin
      n_err++;
      $display("FAIL bypass_take: ce=%b pc=%h cnt=%0d, need 1/100/0", fq_o_ce, fq_o_pc, fq_o_count);
    end
    edge_update();
    drive(1'b1, 32'h100, 1'b1, 1'b0);
    n_vec++;
    if (fq_o_count !== 3'd0 || fq_o_ce !== 1'b1 || fq_o_pc !== 32'h100) begin
      n_err++;
      $display("FAIL bypass_stall: ce=%b pc=%h cnt=%0d, need 1/100/0", fq_o_ce, fq_o_pc, fq_o_count);
    end
    edge_update();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    n_vec++;
    if (fq_o_count !== 3'd1 || fq_o_pc !== 32'h100) begin
      n_err++;
      $display("FAIL bypass_stored: cnt=%0d pc=%h, need 1/100", fq_o_count, fq_o_pc);
    end
    edge_update();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 4);
      n_vec++;
      if (fq_o_ce !== exp_ce() || fq_o_pc !== exp_pc() || fq_o_instr !== exp_instr() ||
          fq_o_count !== 3'(q_pc.size()) || fq_o_ready !== (q_pc.size() != DEPTH) ||
          fq_o_overflow !== m_ovf) begin
        n_err++;
        $display("FAIL random[%0d]: ce=%b pc=%h cnt=%0d rdy=%b ovf=%b, need ce=%b pc=%h cnt=%0d rdy=%b ovf=%b",
                 i, fq_o_ce, fq_o_pc, fq_o_count, fq_o_ready, fq_o_overflow,
                 exp_ce(), exp_pc(), q_pc.size(), (q_pc.size() != DEPTH), m_ovf);
      end
      edge_update();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wrap();
    test_overflow();
    test_flush();
    test_async_reset();
`ifdef FQ_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
